pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter: DATA_W, default 64, payload width in bits (allowed range 1..256).
REQ-002 Parameter: CTRL_W, default 8, control-bundle width in bits (writeback, memread, aluop and similar); allowed range 1..64.
REQ-003 Parameter: PRESET_VAL, default 0, value loaded into the data fields on reset.
REQ-004 Parameter: CNT_W, default 16, width of the stall counter.
REQ-005 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: srst  in  1  reset; synchronous and active-high.
REQ-007 Port: flush  in  1  kills all buffered entries (branch/jump squash).
REQ-008 Port: in_valid  in  1  upstream entry is present.
REQ-009 Port: in_ready  out  1  stage can accept an entry.
REQ-010 Port: in_ctrl  in  CTRL_W  control bundle of the upstream entry.
REQ-011 Port: in_data  in  DATA_W  payload of the upstream entry.
REQ-012 Port: out_valid  out  1  head entry is present.
REQ-013 Port: out_ready  in  1  downstream accepts the head entry.
REQ-014 Port: out_ctrl  out  CTRL_W  control bundle of the head entry.
REQ-015 Port: out_data  out  DATA_W  payload of the head entry.
REQ-016 Port: occupancy  out  2  number of valid entries (0..2).
REQ-017 Port: stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-018 The stage SHALL hold two entries, MAIN (head) and SKID, each consisting of a valid bit, a ctrl field and a data field.
REQ-019 Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 out_valid SHALL equal MAIN.valid, and in_ready SHALL equal !SKID.valid; both SHALL be driven directly from registers with no combinational path from in_valid or out_ready.
REQ-021 Latency: an entry pushed into an empty stage at edge N SHALL appear on the out_* ports after edge N (one cycle).
REQ-022 Empty, push: MAIN SHALL load the input.
REQ-023 MAIN only, push and pop in the same cycle: MAIN SHALL load the input; occupancy SHALL stay 1.
REQ-024 MAIN only, push without pop: SKID SHALL load the input.
REQ-025 MAIN only, pop without push: the stage SHALL become empty.
REQ-026 Both entries full: in_ready SHALL be 0; on pop, SKID SHALL move into MAIN and SKID SHALL clear.
REQ-027 Entries SHALL leave in push order; none SHALL be duplicated or lost, except by flush.
REQ-028 When out_valid is 0, out_ctrl SHALL be all-zero (a bubble); out_data SHALL hold its last value.
REQ-029 With flush=1, both valid bits SHALL clear at the next edge, as SHALL the MAIN and SKID ctrl fields.
REQ-030 Flush SHALL take priority over push and pop in the same cycle: the input is dropped, and the pop still counts as accepted downstream.
REQ-031 stall_cnt SHALL increment once per cycle with out_valid=1 and out_ready=0, and SHALL saturate at 2^CNT_W-1.
REQ-032 stall_cnt SHALL be unaffected by flush.
REQ-033 occupancy SHALL equal MAIN.valid + SKID.valid.

Reset
REQ-034 While srst=1 at an edge, the stage SHALL clear both valid bits and both ctrl fields, load PRESET_VAL into both data fields, and clear stall_cnt.
REQ-035 srst SHALL override flush, push and pop.
REQ-036 After reset: out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_data=PRESET_VAL.
REQ-037 Reset asserted mid-transfer SHALL discard all entries with no partial update; the first edge after srst deasserts SHALL accept a push normally.

Verification
REQ-038 The bench SHALL cover streaming: in_valid=1 and out_ready=1 for 10 cycles with data 1..10 -> out_data 1..10 one cycle later, occupancy=1 throughout, stall_cnt=0.
REQ-039 The bench SHALL cover back-pressure: push A, B with out_ready=0 -> occupancy=2, in_ready=0, stall_cnt increments; raise out_ready -> A then B in order, with no entry lost.
REQ-040 The bench SHALL cover flush while full: flush=1 with in_valid=1 (data C) -> next cycle occupancy=0, out_ctrl=0, and C is never output.
REQ-041 The bench SHALL cover stall-counter saturation: CNT_W=3 and 10 stalled cycles -> stall_cnt=7.
REQ-042 The bench SHALL cover reset mid-operation: occupancy=2, then srst=1 for one cycle -> out_valid=0, in_ready=1, out_data=PRESET_VAL, stall_cnt=0; a push at the next edge appears normally.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stage_skid_if                                              |
// | Brief    : Valid/ready bus bundle for the pipe_stage_skid register stage.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stage_skid                                                 |
// | Brief    : Two-entry (MAIN + SKID) fully registered pipeline stage with    |
// |            flush, bubble insertion and a saturating stall counter.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
    parameter int              DATA_W     = 64,
    parameter int              CTRL_W     = 8,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0,
    parameter int              CNT_W      = 16
) (
    input  wire               clk,
    input  wire               srst,
    pipe_stage_skid_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_stall_max = '1;

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_push;
    logic w_pop;

    assign w_push = bus.in_valid & ~r_skid_valid;
    assign w_pop  = r_main_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= PRESET_VAL;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= PRESET_VAL;
            r_stall_cnt  <= '0;
        end else begin
            if (r_main_valid && !bus.out_ready && r_stall_cnt != c_stall_max) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (bus.flush) begin
                // Data fields keep their values so out_data still holds the last head.
                r_main_valid <= 1'b0;
                r_main_ctrl  <= '0;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
            end else if (r_skid_valid) begin
                if (w_pop) begin
                    r_main_ctrl  <= r_skid_ctrl;
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                end
            end else if (r_main_valid) begin
                if (w_push && w_pop) begin
                    r_main_ctrl <= bus.in_ctrl;
                    r_main_data <= bus.in_data;
                end else if (w_push) begin
                    r_skid_valid <= 1'b1;
                    r_skid_ctrl  <= bus.in_ctrl;
                    r_skid_data  <= bus.in_data;
                end else if (w_pop) begin
                    // Zero the ctrl so the emptied head presents a bubble.
                    r_main_valid <= 1'b0;
                    r_main_ctrl  <= '0;
                end
            end else if (w_push) begin
                r_main_valid <= 1'b1;
                r_main_ctrl  <= bus.in_ctrl;
                r_main_data  <= bus.in_data;
            end
        end
    end

    assign bus.out_valid = r_main_valid;
    assign bus.in_ready  = ~r_skid_valid;
    assign bus.out_ctrl  = r_main_ctrl;
    assign bus.out_data  = r_main_data;
    assign bus.occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_stage_skid                                              |
// | Brief    : Directed vectors plus randomized traffic against a queue model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_skid;
    localparam int              c_data_w = 16;
    localparam int              c_ctrl_w = 4;
    localparam int              c_cnt_w  = 3;
    localparam logic [15:0]     c_preset = 16'hA5C3;
    localparam int              c_smax   = (1 << c_cnt_w) - 1;

    logic clk;
    logic srst;

    pipe_stage_skid_if #(.DATA_W(c_data_w), .CTRL_W(c_ctrl_w), .CNT_W(c_cnt_w)) bus ();

    pipe_stage_skid #(
        .DATA_W    (c_data_w),
        .CTRL_W    (c_ctrl_w),
        .PRESET_VAL(c_preset),
        .CNT_W     (c_cnt_w)
    ) u_dut (
        .clk (clk),
        .srst(srst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [15:0] data;
    } entry_t;

    typedef struct {
        logic        s, f, iv, ordy;
        logic [3:0]  ctrl;
        logic [15:0] data;
        logic        ev, er;
        logic [1:0]  eocc;
        logic [3:0]  ectrl;
        logic [15:0] edata;
        logic [2:0]  estall;
    } vec_t;

    entry_t      m_q[$];
    logic [15:0] m_last;
    int          m_stall;
    int          n_checks;
    int          n_fail;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a bounded FIFO of depth 2 with flush and a saturating stall count.
    task automatic model_update(input logic s, f, iv, ordy, input logic [3:0] c, input logic [15:0] d);
        bit ov;
        bit ir;
        if (s) begin
            m_q.delete();
            m_last  = c_preset;
            m_stall = 0;
            return;
        end
        ov = (m_q.size() > 0);
        ir = (m_q.size() < 2);
        if (ov && !ordy && m_stall < c_smax) m_stall++;
        if (f) begin
            m_q.delete();
        end else begin
            if (ov && ordy) void'(m_q.pop_front());
            if (iv && ir) m_q.push_back('{ctrl: c, data: d});
        end
        if (m_q.size() > 0) m_last = m_q[0].data;
    endtask

    task automatic check_model();
        chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
        chk("mdl_in_ready",  32'(bus.in_ready),  32'(m_q.size() < 2));
        chk("mdl_occupancy", 32'(bus.occupancy), 32'(m_q.size()));
        chk("mdl_out_ctrl",  32'(bus.out_ctrl),  (m_q.size() > 0) ? 32'(m_q[0].ctrl) : 32'd0);
        chk("mdl_out_data",  32'(bus.out_data),  32'(m_last));
        chk("mdl_stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    endtask

    task automatic step(input logic s, f, iv, ordy, input logic [3:0] c, input logic [15:0] d);
        srst          = s;
        bus.flush     = f;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        @(posedge clk);
        model_update(s, f, iv, ordy, c, d);
        #1;
        check_model();
    endtask

    task automatic add_vec(input logic s, f, iv, ordy, input logic [3:0] c, input logic [15:0] d,
                           input logic ev, er, input logic [1:0] eocc, input logic [3:0] ectrl,
                           input logic [15:0] edata, input logic [2:0] estall);
        vec_t v;
        v = '{s: s, f: f, iv: iv, ordy: ordy, ctrl: c, data: d, ev: ev, er: er,
              eocc: eocc, ectrl: ectrl, edata: edata, estall: estall};
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_last   = c_preset;
        m_stall  = 0;

        // Reset state
        add_vec(1, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 0, 4'h0, c_preset, 0);
        // Streaming 1..10
        for (int i = 1; i <= 10; i++)
            add_vec(0, 0, 1, 1, 4'(i), 16'(i), 1, 1, 1, 4'(i), 16'(i), 0);
        add_vec(0, 0, 0, 1, 4'h0, 16'h0000, 0, 1, 0, 4'h0, 16'd10, 0);
        // Back-pressure: A then B held, then drained in order
        add_vec(0, 0, 1, 0, 4'h1, 16'h00AA, 1, 1, 1, 4'h1, 16'h00AA, 0);
        add_vec(0, 0, 1, 0, 4'h2, 16'h00BB, 1, 0, 2, 4'h1, 16'h00AA, 1);
        add_vec(0, 0, 0, 0, 4'h0, 16'h0000, 1, 0, 2, 4'h1, 16'h00AA, 2);
        add_vec(0, 0, 0, 1, 4'h0, 16'h0000, 1, 1, 1, 4'h2, 16'h00BB, 2);
        add_vec(0, 0, 0, 1, 4'h0, 16'h0000, 0, 1, 0, 4'h0, 16'h00BB, 2);
        // Flush while full with C presented on the input
        add_vec(0, 0, 1, 0, 4'h3, 16'h00DD, 1, 1, 1, 4'h3, 16'h00DD, 2);
        add_vec(0, 0, 1, 0, 4'h4, 16'h00EE, 1, 0, 2, 4'h3, 16'h00DD, 3);
        add_vec(0, 1, 1, 0, 4'h5, 16'h00CC, 0, 1, 0, 4'h0, 16'h00DD, 4);
        add_vec(0, 0, 0, 1, 4'h0, 16'h0000, 0, 1, 0, 4'h0, 16'h00DD, 4);

        foreach (vecs[k]) begin
            step(vecs[k].s, vecs[k].f, vecs[k].iv, vecs[k].ordy, vecs[k].ctrl, vecs[k].data);
            chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'(vecs[k].ev));
            chk($sformatf("vec%0d_in_ready", k),  32'(bus.in_ready),  32'(vecs[k].er));
            chk($sformatf("vec%0d_occupancy", k), 32'(bus.occupancy), 32'(vecs[k].eocc));
            chk($sformatf("vec%0d_out_ctrl", k),  32'(bus.out_ctrl),  32'(vecs[k].ectrl));
            chk($sformatf("vec%0d_out_data", k),  32'(bus.out_data),  32'(vecs[k].edata));
            chk($sformatf("vec%0d_stall_cnt", k), 32'(bus.stall_cnt), 32'(vecs[k].estall));
        end

        // Stall counter saturation after ten stalled cycles
        step(1, 0, 0, 0, 4'h0, 16'h0000);
        step(0, 0, 1, 0, 4'h7, 16'h0777);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'h0, 16'h0000);
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd7);
        chk("sat_out_data",  32'(bus.out_data),  32'h0777);

        // Reset with both entries full, then a normal push
        step(0, 0, 1, 0, 4'h8, 16'h0888);
        chk("mid_occ_full", 32'(bus.occupancy), 32'd2);
        step(1, 0, 1, 1, 4'h9, 16'h0999);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  32'(bus.out_data),  32'(c_preset));
        chk("rst_out_ctrl",  32'(bus.out_ctrl),  32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        step(0, 0, 1, 0, 4'h6, 16'h1234);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data",  32'(bus.out_data),  32'h1234);
        chk("post_rst_ctrl",  32'(bus.out_ctrl),  32'h6);
        chk("post_rst_occ",   32'(bus.occupancy), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 4'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
